logic_unit_arbiter: RTL

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters, e.g. the ALU issue port and a second execution/forwarding client.
- Arbitration is round-robin.
- Each result is registered in a single-entry output buffer with a valid/ready handshake and tagged with the requester id.
- Sits between the decode/issue logic and the ALU result mux.

---
 rtl/logic_unit_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR)
// between two requesters, with a single-entry valid/ready result buffer.
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   req0_valid/ready     : requester 0 handshake
//   req0_in1/in2/op      : requester 0 operands and opcode (00 AND, 01 OR, 10 XOR, 11 NOR)
//   req1_valid/ready     : requester 1 handshake
//   req1_in1/in2/op      : requester 1 operands and opcode
//   res_valid/ready      : output buffer handshake
//   res_out              : registered result
//   res_id               : requester that produced res_out
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_id
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_res_out;
    logic             r_res_id;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;

    // A full buffer being drained this cycle can be refilled in the same cycle.
    assign w_can_accept = (r_state == S_EMPTY) || res_ready;

    // On contention the requester that did not win last time is favoured.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_can_accept && w_gnt0;
    assign req1_ready = w_can_accept && w_gnt1;

    assign w_acc0   = req0_valid && req0_ready;
    assign w_acc1   = req1_valid && req1_ready;
    assign w_accept = w_acc0 || w_acc1;

    assign w_op = w_acc1 ? req1_op  : req0_op;
    assign w_a  = w_acc1 ? req1_in1 : req0_in1;
    assign w_b  = w_acc1 ? req1_in2 : req0_in2;

    always_comb begin
        w_result = '0;
        unique case (w_op)
            2'b00: w_result = w_a & w_b;
            2'b01: w_result = w_a | w_b;
            2'b10: w_result = w_a ^ w_b;
            2'b11: w_result = ~(w_a | w_b);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_accept) w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if (res_ready && !w_accept) w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_last_grant <= 1'b1;
            r_res_out    <= '0;
            r_res_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_res_out    <= w_result;
                r_res_id     <= w_acc1;
                r_last_grant <= w_acc1;
            end
        end
    end

    assign res_valid = (r_state == S_FULL);
    assign res_out   = r_res_out;
    assign res_id    = r_res_id;

endmodule
